// File: rtl/gelato_block_dispatcher.sv
// gelato_block_dispatcher: accepts one thread-block launch, splits it into
// WARP_SIZE-thread warps, issues one warp-init per warp and reports block
// completion once every issued warp has signalled done.
// Optional build macro GELATO_DISPATCH_PERF_EN adds perf_blocks and
// perf_busy_cycles counters.
module gelato_block_dispatcher #(
    parameter int WARP_SIZE = 32,
    parameter int NUM_WARPS = 8,
    localparam int IDW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            blk_valid,
    output logic            blk_ready,
    input  logic [31:0]     blk_pc,
    input  logic [95:0]     blk_grid_dim,
    input  logic [95:0]     blk_block_dim,
    input  logic [95:0]     blk_block_idx,
    output logic            warp_valid,
    input  logic            warp_ready,
    output logic [IDW-1:0]  warp_id,
    output logic [31:0]     warp_pc,
    output logic [31:0]     warp_workers,
    output logic [95:0]     warp_grid_dim,
    output logic [95:0]     warp_block_dim,
    output logic [95:0]     warp_block_idx,
    input  logic            warp_done,
    input  logic [IDW-1:0]  warp_done_id,
    output logic            blk_done,
    output logic            blk_err
`ifdef GELATO_DISPATCH_PERF_EN
    ,
    output logic [31:0]     perf_blocks,
    output logic [31:0]     perf_busy_cycles
`endif
);

    localparam int          WS_LOG  = (WARP_SIZE > 1) ? $clog2(WARP_SIZE) : 0;
    localparam logic [31:0] WS_MASK = 32'(WARP_SIZE - 1);
    localparam logic [31:0] WS_VAL  = 32'(WARP_SIZE);

    typedef enum logic [1:0] {IDLE, CALC, DISPATCH, WAIT} stateT;

    typedef struct packed {
        logic [31:0] pc;
        logic [95:0] gridDim;
        logic [95:0] blockDim;
        logic [95:0] blockIdx;
    } launchT;

    stateT                state;
    launchT               launch;
    logic [31:0]          remaining;
    logic [NUM_WARPS-1:0] active;

    logic [31:0]          threads;
    logic [31:0]          nwarps;
    logic                 xferFire;
    logic                 lastXfer;
    logic [NUM_WARPS-1:0] setMask;
    logic [NUM_WARPS-1:0] clrMask;
    logic [NUM_WARPS-1:0] activeNext;

    function automatic logic [31:0] capWorkers(input logic [31:0] n);
        return (n > WS_VAL) ? WS_VAL : n;
    endfunction

    // Block geometry: thread count wraps at 32 bits, warp count rounds up
    // without forming threads+WARP_SIZE-1 (which could overflow).
    assign threads = launch.blockDim[31:0] * launch.blockDim[63:32] * launch.blockDim[95:64];
    assign nwarps  = (threads >> WS_LOG) + {31'd0, |(threads & WS_MASK)};

    assign xferFire = warp_valid && warp_ready;
    assign lastXfer = xferFire && (remaining == warp_workers);

    // Active-warp bookkeeping: a dispatch in the same cycle as a done for
    // the same slot is a fresh warp, so the set is applied after the clear.
    always_comb begin
        setMask    = xferFire  ? (NUM_WARPS'(1) << warp_id)      : '0;
        clrMask    = warp_done ? (NUM_WARPS'(1) << warp_done_id) : '0;
        activeNext = (active & ~clrMask) | setMask;
    end

    // Main FSM with registered handshake, warp-init and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            launch         <= '0;
            remaining      <= '0;
            active         <= '0;
            blk_ready      <= 1'b1;
            warp_valid     <= 1'b0;
            warp_id        <= '0;
            warp_pc        <= '0;
            warp_workers   <= '0;
            warp_grid_dim  <= '0;
            warp_block_dim <= '0;
            warp_block_idx <= '0;
            blk_done       <= 1'b0;
            blk_err        <= 1'b0;
        end else begin
            active   <= activeNext;
            blk_done <= 1'b0;
            blk_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // blk_ready re-arms one cycle after blk_done so a launch
                    // is never taken in the completion cycle.
                    if (blk_ready && blk_valid) begin
                        launch    <= '{blk_pc, blk_grid_dim, blk_block_dim, blk_block_idx};
                        blk_ready <= 1'b0;
                        state     <= CALC;
                    end else begin
                        blk_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (threads == '0) begin
                        blk_done <= 1'b1;
                        state    <= IDLE;
                    end else if (nwarps > 32'(NUM_WARPS)) begin
                        blk_done <= 1'b1;
                        blk_err  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        remaining      <= threads;
                        warp_valid     <= 1'b1;
                        warp_id        <= '0;
                        warp_workers   <= capWorkers(threads);
                        warp_pc        <= launch.pc;
                        warp_grid_dim  <= launch.gridDim;
                        warp_block_dim <= launch.blockDim;
                        warp_block_idx <= launch.blockIdx;
                        state          <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (xferFire) begin
                        remaining <= remaining - warp_workers;
                        if (lastXfer) begin
                            warp_valid <= 1'b0;
                            state      <= WAIT;
                        end else begin
                            warp_id      <= warp_id + 1'b1;
                            warp_workers <= capWorkers(remaining - warp_workers);
                        end
                    end
                end
                WAIT: begin
                    if (active == '0) begin
                        blk_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GELATO_DISPATCH_PERF_EN
    // Free-running, wrapping counters of clean block completions and busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_blocks      <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if (blk_done && !blk_err) perf_blocks <= perf_blocks + 32'd1;
            if (state != IDLE)        perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule
